// File: rtl/regfile_dumper_pkg.sv
// rtl/regfile_dumper_pkg.sv - shared widths and FSM encoding for the register-file dumper
// Contents: default data/address/byte widths and the dumper state encoding.
package regfile_dumper_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_ADDR_DEF = 5;
  localparam int NB_BYTE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dumper.sv
// rtl/regfile_dumper.sv - streams every register of a register file out as bytes, MSB first
// Ports:
//   clk          single clock, all logic on its rising edge
//   i_rst        synchronous active-high reset
//   i_start      begin a dump (only looked at while idle)
//   o_rd_addr    address to the combinational register-file read port
//   i_rd_data    read data for o_rd_addr, same cycle
//   o_tx_data    byte offered downstream
//   o_tx_valid   o_tx_data is valid
//   i_tx_ready   downstream accepts the byte this cycle
//   o_busy       high whenever not idle
//   o_done       one-cycle pulse after the last byte is accepted
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF,
  parameter int NB_BYTE = NB_BYTE_DEF
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_rd_addr,
  input  logic [NB_DATA-1:0] i_rd_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NBYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(NBYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tx_xfer;

  assign tx_xfer = tx_valid_q && i_tx_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Snapshot the register now so later writes cannot alter its bytes.
        shift_d = i_rd_data;
        cnt_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_xfer) begin
          if (cnt_q != LAST_BYTE) begin
            shift_d = shift_q << NB_BYTE;
            cnt_d   = cnt_q + 1'b1;
          end else if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_LOAD;
          end else begin
            // Address is left at the last register rather than wrapping.
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Status outputs are registered from the next state so they line up with it.
    tx_valid_d = (state_d == ST_SEND);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_rd_addr  = addr_q;
  assign o_tx_data  = shift_q[NB_DATA-1 -: NB_BYTE];
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// tb/tb_regfile_dumper.sv - self-checking bench for regfile_dumper
module tb_regfile_dumper;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int NB_BYTE = 8;
  localparam int NREGS   = 1 << NB_ADDR;

  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_start = 1'b0;
  logic [NB_ADDR-1:0] o_rd_addr;
  logic [NB_DATA-1:0] i_rd_data;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready = 1'b1;
  logic               o_busy;
  logic               o_done;

  logic [NB_DATA-1:0] regs [NREGS];
  logic [NB_BYTE-1:0] exp_q [$];

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  bytes_seen = 0;
  int  done_cnt = 0;
  int  done_rel = -1;
  bit  check_busy = 1'b0;
  bit  stall_q = 1'b0;
  logic [NB_BYTE-1:0] stall_data = '0;

  always #5 clk = ~clk;

  assign i_rd_data = regs[o_rd_addr];

  regfile_dumper #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR),
    .NB_BYTE(NB_BYTE)
  ) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .o_rd_addr (o_rd_addr),
    .i_rd_data (i_rd_data),
    .o_tx_data (o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_all();
    for (int r = 0; r < NREGS; r++)
      for (int b = 0; b < NB_DATA / NB_BYTE; b++)
        exp_q.push_back(regs[r][NB_DATA-1-b*NB_BYTE -: NB_BYTE]);
  endtask

  task automatic monitor();
    int rel;
    logic [NB_BYTE-1:0] e;
    rel = cyc - start_cyc;
    if (check_busy && rel <= 165) chk("busy_window", o_busy, (rel >= 1 && rel <= 161));
    if (o_done === 1'b1) begin
      done_cnt++;
      if (done_cnt == 1) done_rel = rel;
    end
    if (o_tx_valid === 1'b1 && stall_q) chk("stall_hold", o_tx_data, stall_data);
    stall_q    = (o_tx_valid === 1'b1) && (i_tx_ready !== 1'b1) && (i_rst !== 1'b1);
    stall_data = o_tx_data;
    if (o_tx_valid === 1'b1 && i_tx_ready === 1'b1 && i_rst !== 1'b1) begin
      bytes_seen++;
      chk("byte_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_byte", o_tx_data, e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_dump(input bit slow, input int restart_at, input int rst_at,
                          input bit late_wr5, input bit chk_busy);
    bit restarted;
    bit written;
    restarted  = 1'b0;
    written    = 1'b0;
    push_all();
    bytes_seen = 0;
    done_cnt   = 0;
    done_rel   = -1;
    i_start    = 1'b1;
    i_tx_ready = slow ? ((cyc % 3) == 0) : 1'b1;
    tick();
    i_start    = 1'b0;
    start_cyc  = cyc - 1;
    check_busy = chk_busy;
    for (int n = 0; n < 2000; n++) begin
      if (done_cnt != 0) break;
      i_tx_ready = slow ? ((cyc % 3) == 0) : 1'b1;
      i_start    = 1'b0;
      if (restart_at >= 0 && !restarted && bytes_seen >= restart_at) begin
        i_start   = 1'b1;
        restarted = 1'b1;
      end
      if (late_wr5 && !written && o_rd_addr == 5 && o_tx_valid === 1'b1) begin
        regs[5] = 32'hDEAD_BEEF;
        written = 1'b1;
      end
      if (rst_at >= 0 && bytes_seen >= rst_at) begin
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("rst_abort_valid", o_tx_valid, 0);
        chk("rst_abort_busy", o_busy, 0);
        exp_q.delete();
        check_busy = 1'b0;
        return;
      end
      tick();
    end
    i_start = 1'b0;
    repeat (6) tick();
    check_busy = 1'b0;
    chk("done_pulses", done_cnt, 1);
    chk("byte_count", bytes_seen, 128);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_after_done", o_busy, 0);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) regs[i] = 32'hA500_0000 + i;

    // reset state
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst_valid", o_tx_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_addr", o_rd_addr, 0);
    chk("rst_data", o_tx_data, 0);
    tick();
    chk("idle_no_start", o_busy, 0);

    // full dump, ready held high, exact timing
    run_dump(1'b0, -1, -1, 1'b0, 1'b1);
    chk("done_cycle", done_rel, 161);
    chk("last_addr_no_wrap", o_rd_addr, NREGS - 1);

    // downstream ready one cycle in three
    run_dump(1'b1, -1, -1, 1'b0, 1'b0);

    // start pulsed mid-dump is ignored
    run_dump(1'b0, 10, -1, 1'b0, 1'b0);

    // reset at byte 50 aborts, then a clean dump from register 0
    run_dump(1'b0, -1, 50, 1'b0, 1'b0);
    repeat (3) tick();
    chk("post_abort_busy", o_busy, 0);
    chk("post_abort_addr", o_rd_addr, 0);
    run_dump(1'b0, -1, -1, 1'b0, 1'b0);

    // write to reg 5 after its snapshot: old bytes go out
    run_dump(1'b0, -1, -1, 1'b1, 1'b0);
    regs[5] = 32'hA500_0005;

    // write to reg 5 before the dump: new bytes go out
    regs[5] = 32'hDEAD_BEEF;
    run_dump(1'b1, -1, -1, 1'b0, 1'b0);
    regs[5] = 32'hA500_0005;

    // start and reset together: stays idle
    i_start = 1'b1;
    i_rst   = 1'b1;
    tick();
    i_start = 1'b0;
    i_rst   = 1'b0;
    bytes_seen = 0;
    repeat (4) begin
      tick();
      chk("start_rst_busy", o_busy, 0);
      chk("start_rst_valid", o_tx_valid, 0);
    end
    chk("start_rst_bytes", bytes_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
